char_gen_multi: RTL and testbench
=================================

Name: char_gen_multi

Overview:
- Parametrised successor to the single-mode character generator.
- Converts one text cell (char code + attributes + scanline) into a serial pixel stream with colour, for 6847-style video paths.
- Supports ROM glyph width/height, line and pixel scaling, inverse video, and semigraphics-4 block mode.
- Sits between the video timing/VRAM fetch logic and the palette/DAC stage; one instance per display.

Parameters:
- CHAR_W, 8, glyph pixels per cell (1..16).
- ROM_ROWS, 16, rows stored per glyph in ROM (power of 2).
- CHAR_ROWS, 12, visible rows per glyph (<= ROM_ROWS).
- LINE_DIV, 2, scanlines per glyph row (1 or 2).
- PIX_DIV, 2, pixel_clock cycles per pixel (1 or 2).
- ROM_FILE, "./roms/charrom_4k.mif", glyph ROM init file.

Ports:
- pixel_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- cell_start  in  1  one-cycle strobe; cell inputs valid this cycle
- char_code  in  8  character code
- subchar_line  in  5  scanline within cell (pre-scaling)
- gfx_en  in  1  1 = code[7] selects semigraphics-4
- inverse  in  1  invert alphanumeric pixels
- fg_color  in  3  alphanumeric foreground colour
- blank  in  1  force pixel_on=0 (sampled each cycle)
- pixel_on  out  1  current pixel lit
- pixel_color  out  3  colour for current pixel
- pixel_valid  out  1  a cell is being serialised

Behaviour:
- Reset (async): pixel_on=0, pixel_color=0, pixel_valid=0, shifter cleared, pixel/phase counters 0.
- Glyph row: row = subchar_line / LINE_DIV (LINE_DIV=1: row = subchar_line[3:0]; LINE_DIV=2: row = subchar_line[4:1]).
- ROM address: {char_code, row[log2(ROM_ROWS)-1:0]}; sync ROM, one-cycle latency.
- Cycle t: cell_start sampled; mode, colour and row are registered into a cell context.
- Cycle t+1: ROM data is valid and the pattern is built:
  - Alnum (gfx_en=0 or code[7]=0): ROM byte; XOR all bits if inverse; colour = fg_color.
  - SG4 (gfx_en=1 and code[7]=1): upper half = row < CHAR_ROWS/2.
    - Upper half: left pixels (index < CHAR_W/2) = code[3], right pixels = code[2].
    - Lower half: left = code[1], right = code[0].
    - Colour = code[6:4]; inverse is ignored.
  - row >= CHAR_ROWS: pattern = all 0 in both modes; in alnum with inverse=1, all 1.
- Serialisation:
  - Pattern bit 0 is displayed first (leftmost).
  - First pixel appears on outputs at t+2; each pixel is held PIX_DIV cycles.
  - Cell lasts CHAR_W*PIX_DIV cycles; pixel_valid=1 throughout.
- Back-to-back cells: cell_start at t+CHAR_W*PIX_DIV gives a gapless stream, and the next cell's pixel 0 directly follows the last pixel.
- Early cell_start (mid-cell): the current cell is aborted at the reload point (t'+2); no glitch cycle.
- No further cell_start: after the last pixel, pixel_valid=0, pixel_on=0, pixel_color holds its last value.
- blank=1: pixel_on=0 that cycle. Counters and pixel_valid are unaffected.
- Reset mid-cell: outputs return to reset values immediately; the next cell_start after release behaves as the first cell.
- Widths: CHAR_W > 8 uses ROM bits [7:0] padded with 0 on the right.

Decomposition:
- Shared package char_gen_pkg:
  - Constants MODE_ALNUM, MODE_SG4.
  - SG4 quadrant bit indices (QUAD_UL=3, QUAD_UR=2, QUAD_LL=1, QUAD_LR=0).
  - Function clog2 for ROM address width.
- ROM: existing sprom instance.
- One sub-module: char_gen_shifter.
  - Parallel load of CHAR_W bits plus colour, PIX_DIV prescaler, pixel counter, pixel_valid.
  - Mode decode and pattern build stay in the top module.

Test Plan:
- Alnum: ROM glyph 0x41 row 2 = 0x1C, LINE_DIV=2, subchar_line=5, PIX_DIV=2, fg_color=3, cell_start at t -> from t+2, pixel sequence 0,0,1,1,1,0,0,0, each held 2 cycles; pixel_color=3; pixel_valid high 16 cycles.
- Inverse on the same cell -> sequence 1,1,0,0,0,1,1,1.
- SG4: gfx_en=1, code=0xA9 (colour 2, quads 1001).
  - subchar_line=2 -> left 4 px on, right 4 off, colour 2.
  - subchar_line=14 -> left off, right on.
- Back-to-back: 3 cells with cell_start every 16 cycles -> 48 contiguous valid cycles, no gap, pattern boundaries exact.
- Row overflow: subchar_line=26 (row 13 >= 12) -> all pixels 0 (alnum, inverse=0); all 1 with inverse=1.
- Reset asserted at pixel 3 of a cell -> outputs 0 within the same cycle; after release, no pixels until the next cell_start, which again emits at +2.

Source files
------------

// File: rtl/char_gen_pkg.sv
// rtl/char_gen_pkg.sv - shared cell modes, SG4 quadrant bit positions and width helper
package char_gen_pkg;

    typedef enum logic {
        MODE_ALNUM = 1'b0,
        MODE_SG4   = 1'b1
    } cell_mode_e;

    localparam int QUAD_UL = 3;
    localparam int QUAD_UR = 2;
    localparam int QUAD_LL = 1;
    localparam int QUAD_LR = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/char_gen_multi_shifter.sv
// rtl/char_gen_multi_shifter.sv - parallel-load pixel serialiser with prescaler and cell timing
module char_gen_shifter
    import char_gen_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int PIX_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CHAR_W-1:0] pattern_i,
    input  logic [2:0]        color_i,
    output logic              pixel_bit_o,
    output logic [2:0]        pixel_color_o,
    output logic              pixel_valid_o
);

    localparam int CNT_W = (clog2(CHAR_W) > 0) ? clog2(CHAR_W) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(CHAR_W - 1);

    logic [CHAR_W-1:0] shift_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic              phase_q;
    logic              bit_q;
    logic              valid_q;
    logic [2:0]        color_q;
    logic              pix_done;

    assign pix_done = (PIX_DIV == 1) || phase_q;

    // A load always wins, so a new cell cleanly replaces whatever was being shifted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            pix_cnt_q <= '0;
            phase_q   <= 1'b0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            color_q   <= '0;
        end else if (load_i) begin
            shift_q   <= pattern_i >> 1;
            bit_q     <= pattern_i[0];
            pix_cnt_q <= '0;
            phase_q   <= 1'b0;
            valid_q   <= 1'b1;
            color_q   <= color_i;
        end else if (valid_q) begin
            phase_q <= !pix_done;
            if (pix_done) begin
                if (pix_cnt_q == LAST_PIX) begin
                    valid_q <= 1'b0;
                    bit_q   <= 1'b0;
                end else begin
                    pix_cnt_q <= pix_cnt_q + 1'b1;
                    bit_q     <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                end
            end
        end
    end

    assign pixel_bit_o   = bit_q;
    assign pixel_color_o = color_q;
    assign pixel_valid_o = valid_q;

endmodule

// File: rtl/sprom.sv
// rtl/sprom.sv - synchronous glyph ROM, one-cycle read latency
module sprom #(
    parameter int ADDR_W    = 12,
    parameter     INIT_FILE = "./roms/charrom_4k.mif"
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [7:0]        data_o
);

    // Only the charrom_4k glyph set is compiled in; any other name gives a blank ROM.
    localparam bit BUILTIN = (INIT_FILE == "./roms/charrom_4k.mif");

    function automatic logic [7:0] glyph_byte(input logic [ADDR_W-1:0] a);
        logic [7:0] code;
        logic [3:0] row;
        logic [7:0] g;
        code = a[ADDR_W-1 -: 8];
        row  = 4'(a[ADDR_W-9:0]);
        if (code == 8'h41) begin
            case (row)
                4'd1:                    g = 8'h08;
                4'd2:                    g = 8'h1C;
                4'd3:                    g = 8'h36;
                4'd4, 4'd5, 4'd7, 4'd8:  g = 8'h22;
                4'd6:                    g = 8'h3E;
                default:                 g = 8'h00;
            endcase
        end else begin
            g = (code * 8'd37) ^ {row, row};
        end
        return g;
    endfunction

    always_ff @(posedge clk_i) begin
        data_o <= BUILTIN ? glyph_byte(addr_i) : 8'h00;
    end

endmodule

// File: rtl/char_gen_multi.sv
// rtl/char_gen_multi.sv - text cell to serial pixel stream, alphanumeric and semigraphics-4
module char_gen_multi
    import char_gen_pkg::*;
#(
    parameter int CHAR_W    = 8,
    parameter int ROM_ROWS  = 16,
    parameter int CHAR_ROWS = 12,
    parameter int LINE_DIV  = 2,
    parameter int PIX_DIV   = 2,
    parameter     ROM_FILE  = "./roms/charrom_4k.mif"
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       cell_start,
    input  logic [7:0] char_code,
    input  logic [4:0] subchar_line,
    input  logic       gfx_en,
    input  logic       inverse,
    input  logic [2:0] fg_color,
    input  logic       blank,
    output logic       pixel_on,
    output logic [2:0] pixel_color,
    output logic       pixel_valid
);

    localparam int ROW_AW   = clog2(ROM_ROWS);
    localparam int ROM_AW   = 8 + ROW_AW;
    localparam int HALF_W   = CHAR_W / 2;
    localparam int ROM_BITS = (CHAR_W < 8) ? CHAR_W : 8;
    localparam logic [4:0] ROW_LIMIT  = 5'(CHAR_ROWS);
    localparam logic [4:0] HALF_LIMIT = 5'(CHAR_ROWS / 2);

    logic [3:0]        row;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    assign row      = (LINE_DIV == 2) ? subchar_line[4:1] : subchar_line[3:0];
    assign rom_addr = {char_code, row[ROW_AW-1:0]};

    sprom #(
        .ADDR_W    (ROM_AW),
        .INIT_FILE (ROM_FILE)
    ) u_rom (
        .clk_i  (pixel_clock),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Cell context captured alongside the ROM read so both line up one cycle later.
    cell_mode_e mode_d, mode_q;
    logic [6:0] code_q;
    logic [3:0] row_q;
    logic       inv_q;
    logic [2:0] fg_q;
    logic       load_q;

    assign mode_d = (gfx_en && char_code[7]) ? MODE_SG4 : MODE_ALNUM;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_ALNUM;
            code_q <= '0;
            row_q  <= '0;
            inv_q  <= 1'b0;
            fg_q   <= '0;
            load_q <= 1'b0;
        end else begin
            load_q <= cell_start;
            if (cell_start) begin
                mode_q <= mode_d;
                code_q <= char_code[6:0];
                row_q  <= row;
                inv_q  <= inverse;
                fg_q   <= fg_color;
            end
        end
    end

    logic [CHAR_W-1:0] pattern_d;
    logic [2:0]        color_d;
    logic              row_visible;
    logic              upper_half;

    assign row_visible = ({1'b0, row_q} < ROW_LIMIT);
    assign upper_half  = ({1'b0, row_q} < HALF_LIMIT);

    always_comb begin
        pattern_d = '0;
        color_d   = fg_q;
        if (mode_q == MODE_SG4) begin
            color_d = code_q[6:4];
            if (row_visible) begin
                for (int i = 0; i < CHAR_W; i++) begin
                    if (upper_half) begin
                        pattern_d[i] = (i < HALF_W) ? code_q[QUAD_UL] : code_q[QUAD_UR];
                    end else begin
                        pattern_d[i] = (i < HALF_W) ? code_q[QUAD_LL] : code_q[QUAD_LR];
                    end
                end
            end
        end else begin
            if (row_visible) begin
                for (int i = 0; i < ROM_BITS; i++) begin
                    pattern_d[i] = rom_data[i];
                end
            end
            if (inv_q) begin
                pattern_d = ~pattern_d;
            end
        end
    end

    logic pix_bit;

    char_gen_shifter #(
        .CHAR_W  (CHAR_W),
        .PIX_DIV (PIX_DIV)
    ) u_shifter (
        .clk_i         (pixel_clock),
        .rst_i         (reset),
        .load_i        (load_q),
        .pattern_i     (pattern_d),
        .color_i       (color_d),
        .pixel_bit_o   (pix_bit),
        .pixel_color_o (pixel_color),
        .pixel_valid_o (pixel_valid)
    );

    assign pixel_on = pix_bit & ~blank;

endmodule

// File: tb/tb_char_gen_multi.sv
// tb/tb_char_gen_multi.sv - randomized bench for char_gen_multi against a cell-level model
module tb_char_gen_multi;

    localparam int CW   = 8;
    localparam int PD   = 2;
    localparam int CELL = CW * PD;
    localparam int NCYC = 8192;

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b1;
    logic       cell_start = 1'b0;
    logic [7:0] char_code = 8'h00;
    logic [4:0] subchar_line = 5'd0;
    logic       gfx_en = 1'b0;
    logic       inverse = 1'b0;
    logic [2:0] fg_color = 3'd0;
    logic       blank = 1'b0;
    logic       pixel_on;
    logic [2:0] pixel_color;
    logic       pixel_valid;

    char_gen_multi dut (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .cell_start   (cell_start),
        .char_code    (char_code),
        .subchar_line (subchar_line),
        .gfx_en       (gfx_en),
        .inverse      (inverse),
        .fg_color     (fg_color),
        .blank        (blank),
        .pixel_on     (pixel_on),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid)
    );

    always #5 pixel_clock = ~pixel_clock;

    int cyc = 0;
    always @(posedge pixel_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Expected output per absolute cycle.
    bit         exp_valid [NCYC];
    bit         exp_on    [NCYC];
    logic [2:0] exp_color [NCYC];
    bit         blank_hist[NCYC];

    logic [7:0] glyph_a [16] = '{8'h00, 8'h08, 8'h1C, 8'h36, 8'h22, 8'h22, 8'h3E, 8'h22,
                                 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] rom_model(input logic [7:0] code, input int row);
        logic [3:0] r;
        r = row[3:0];
        if (code == 8'h41) return glyph_a[r];
        return (code * 8'd37) ^ {r, r};
    endfunction

    // pat bit i is the i-th pixel from the left.
    function automatic void cell_model(input logic [7:0] code, input logic [4:0] line,
                                       input bit gfx, input bit inv, input logic [2:0] fg,
                                       output logic [7:0] pat, output logic [2:0] col);
        int row;
        row = int'(line) / 2;
        if (gfx && code[7]) begin
            col = code[6:4];
            for (int i = 0; i < CW; i++)
                pat[i] = (row >= 12) ? 1'b0 : code[(row < 6 ? 2 : 0) + (i < 4 ? 1 : 0)];
        end else begin
            col = fg;
            pat = (row >= 12) ? 8'h00 : rom_model(code, row);
            if (inv) pat = ~pat;
        end
    endfunction

    function automatic void schedule(input int t, input logic [7:0] code, input logic [4:0] line,
                                     input bit gfx, input bit inv, input logic [2:0] fg);
        logic [7:0] pat;
        logic [2:0] col;
        cell_model(code, line, gfx, inv, fg, pat, col);
        for (int k = 0; k < CELL; k++) begin
            if (t + 2 + k < NCYC) begin
                exp_valid[t + 2 + k] = 1'b1;
                exp_on[t + 2 + k]    = pat[k / PD];
                exp_color[t + 2 + k] = col;
            end
        end
    endfunction

    task automatic tick(input bit start, input logic [7:0] code, input logic [4:0] line,
                        input bit gfx, input bit inv, input logic [2:0] fg, input bit blk);
        cell_start   = start;
        char_code    = code;
        subchar_line = line;
        gfx_en       = gfx;
        inverse      = inv;
        fg_color     = fg;
        blank        = blk;
        blank_hist[cyc] = blk;
        if (start) schedule(cyc, code, line, gfx, inv, fg);
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 8'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
    endtask

    // Compare process: every cycle, mid-cycle.
    bit         checking = 1'b0;
    logic [2:0] last_color = 3'd0;
    bit         count_en = 1'b0;
    bit         prev_valid = 1'b0;
    int         valid_cnt = 0;
    int         valid_rises = 0;
    bit         e_valid, e_on;
    logic [2:0] e_color;

    always @(negedge pixel_clock) begin
        if (checking) begin
            if (reset) begin
                check("reset_valid", int'(pixel_valid), 0);
                check("reset_on", int'(pixel_on), 0);
                check("reset_color", int'(pixel_color), 0);
                last_color = 3'd0;
            end else begin
                e_valid = exp_valid[cyc];
                e_on    = e_valid && exp_on[cyc] && !blank_hist[cyc];
                e_color = e_valid ? exp_color[cyc] : last_color;
                check("pixel_valid", int'(pixel_valid), int'(e_valid));
                check("pixel_on", int'(pixel_on), int'(e_on));
                check("pixel_color", int'(pixel_color), int'(e_color));
                last_color = e_color;
            end
        end
        if (count_en) begin
            valid_cnt   += int'(pixel_valid);
            valid_rises += int'(pixel_valid && !prev_valid);
            prev_valid   = pixel_valid;
        end
    end

    logic [7:0]  mp;
    logic [2:0]  mc;
    logic [15:0] seq;
    int          gap;

    initial begin
        checking = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Model pinned to hand-derived values.
        cell_model(8'h41, 5'd5, 1'b0, 1'b0, 3'd3, mp, mc);
        check("model_alnum_pat", int'(mp), 'h1C);
        check("model_alnum_col", int'(mc), 3);
        cell_model(8'h41, 5'd5, 1'b0, 1'b1, 3'd3, mp, mc);
        check("model_inverse_pat", int'(mp), 'hE3);
        cell_model(8'hA9, 5'd2, 1'b1, 1'b0, 3'd5, mp, mc);
        check("model_sg4_upper_pat", int'(mp), 'h0F);
        check("model_sg4_col", int'(mc), 2);
        cell_model(8'hA9, 5'd14, 1'b1, 1'b1, 3'd5, mp, mc);
        check("model_sg4_lower_pat", int'(mp), 'hF0);
        cell_model(8'h41, 5'd26, 1'b0, 1'b0, 3'd1, mp, mc);
        check("model_overflow_pat", int'(mp), 'h00);
        cell_model(8'h41, 5'd26, 1'b0, 1'b1, 3'd1, mp, mc);
        check("model_overflow_inv_pat", int'(mp), 'hFF);

        // Alnum 'A' row 2, captured directly from the DUT.
        tick(1'b1, 8'h41, 5'd5, 1'b0, 1'b0, 3'd3, 1'b0);
        idle(1);
        for (int k = 0; k < CELL; k++) begin
            seq[k] = pixel_on;
            idle(1);
        end
        check("alnum_sequence", int'(seq), 'h03F0);
        check("alnum_done_valid", int'(pixel_valid), 0);
        check("alnum_hold_color", int'(pixel_color), 3);
        idle(4);

        tick(1'b1, 8'h41, 5'd5, 1'b0, 1'b1, 3'd3, 1'b0);  idle(CELL + 3);
        tick(1'b1, 8'hA9, 5'd2, 1'b1, 1'b0, 3'd6, 1'b0);  idle(CELL + 3);
        tick(1'b1, 8'hA9, 5'd14, 1'b1, 1'b1, 3'd6, 1'b0); idle(CELL + 3);
        tick(1'b1, 8'h41, 5'd26, 1'b0, 1'b0, 3'd1, 1'b0); idle(CELL + 3);
        tick(1'b1, 8'h41, 5'd26, 1'b0, 1'b1, 3'd1, 1'b0); idle(CELL + 3);

        // Three back-to-back cells.
        count_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 8'h41 + 8'(c), 5'd5, 1'b0, 1'b0, 3'(c + 4), 1'b0);
            idle(CELL - 1);
        end
        idle(12);
        count_en = 1'b0;
        check("b2b_valid_cycles", valid_cnt, 48);
        check("b2b_valid_bursts", valid_rises, 1);

        // Reset at pixel 3.
        tick(1'b1, 8'h41, 5'd5, 1'b0, 1'b0, 3'd7, 1'b0);
        idle(7);
        reset = 1'b1;
        for (int c = cyc; c < NCYC; c++) exp_valid[c] = 1'b0;
        #1;
        check("midcell_reset_valid", int'(pixel_valid), 0);
        check("midcell_reset_color", int'(pixel_color), 0);
        idle(2);
        reset = 1'b0;
        idle(20);
        tick(1'b1, 8'h41, 5'd5, 1'b0, 1'b0, 3'd5, 1'b0);
        idle(CELL + 3);

        // Random cells: exact back-to-back, early restarts, and gaps, with random blanking.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: gap = CELL;
                5, 6:          gap = int'($urandom_range(1, CELL - 1));
                default:       gap = int'($urandom_range(CELL + 1, CELL + 8));
            endcase
            tick(1'b1, 8'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 9) == 0));
            for (int i = 1; i < gap; i++)
                tick(1'b0, 8'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                     ($urandom_range(0, 9) == 0));
        end
        idle(CELL + 4);
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
